// File: rtl/riscv_pkg.sv
// Shared RISC-V encoding definitions: immediate-format codes, encodable
// immediate ranges, the FIFO entry payload and the immediate extender
// that decodes a packed word back to its sign-extended immediate.
package riscv_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned REG_W     = 5;
   localparam int unsigned OPC_W     = 7;
   localparam int unsigned F3_W      = 3;
   localparam int unsigned FMT_W     = 2;
   localparam int unsigned ERR_CNT_W = 8;

   typedef enum logic [FMT_W-1:0] {
      FMT_I   = 2'b00,
      FMT_S   = 2'b01,
      FMT_B   = 2'b10,
      FMT_ILL = 2'b11
   } fmt_e;

   // Byte-immediate limits; B-type spans 13 bits with an implicit zero LSB.
   localparam int IMM12_MIN = -2048;
   localparam int IMM12_MAX = 2047;
   localparam int IMM13_MIN = -4096;
   localparam int IMM13_MAX = 4094;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic            err;
   } fifo_entry_t;

   // Recover the sign-extended immediate from an encoded word.
   function automatic logic [XLEN-1:0] imm_extend(input fmt_e fmt, input logic [XLEN-1:0] instr);
      logic [XLEN-1:0] imm;
      imm = {{20{instr[31]}}, instr[31:20]};
      case (fmt)
         FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         default: ;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational field packer and immediate range checker.
// Ports: fmt/opcode/rd/rs1/rs2/funct3/imm request fields in;
//        instr_c encoded word, err_c immediate not encodable (or illegal fmt).
module imm_pack
   import riscv_pkg::*;
(
   input  logic [FMT_W-1:0] fmt,
   input  logic [OPC_W-1:0] opcode,
   input  logic [REG_W-1:0] rd,
   input  logic [REG_W-1:0] rs1,
   input  logic [REG_W-1:0] rs2,
   input  logic [F3_W-1:0]  funct3,
   input  logic [XLEN-1:0]  imm,
   output logic [XLEN-1:0]  instr_c,
   output logic             err_c
);

   logic signed [XLEN-1:0] imm_s;
   logic                   out12;
   logic                   out13;

   assign imm_s = imm;
   assign out12 = (imm_s < IMM12_MIN) || (imm_s > IMM12_MAX);
   assign out13 = (imm_s < IMM13_MIN) || (imm_s > IMM13_MAX);

   // Illegal format falls back to the I-type layout but is always flagged.
   always_comb begin
      instr_c = {imm[11:0], rs1, funct3, rd, opcode};
      err_c   = 1'b1;
      case (fmt_e'(fmt))
         FMT_I: err_c = out12;
         FMT_S: begin
            instr_c = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            err_c   = out12;
         end
         FMT_B: begin
            instr_c = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            err_c   = out13 | imm[0];
         end
         FMT_ILL: err_c = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: packs I/S/B requests into 32-bit words, queues them
// in a 2-entry FIFO and tags each emitted word with a running word address.
// Ports: clk, rst (sync, active high), clear (sync flush);
//        in_valid/in_ready + in_fmt/in_opcode/in_rd/in_rs1/in_rs2/in_funct3/in_imm;
//        out_valid/out_ready + out_instr/out_addr/out_err; err_count.
module instr_encoder
   import riscv_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [FMT_W-1:0]     in_fmt,
   input  logic [OPC_W-1:0]     in_opcode,
   input  logic [REG_W-1:0]     in_rd,
   input  logic [REG_W-1:0]     in_rs1,
   input  logic [REG_W-1:0]     in_rs2,
   input  logic [F3_W-1:0]      in_funct3,
   input  logic [XLEN-1:0]      in_imm,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      out_instr,
   output logic [XLEN-1:0]      out_addr,
   output logic                 out_err,
   output logic [ERR_CNT_W-1:0] err_count
);

   logic [XLEN-1:0]      pack_instr;
   logic                 pack_err;
   fifo_entry_t          new_entry;
   fifo_entry_t          head_q, head_d;
   fifo_entry_t          tail_q, tail_d;
   logic [1:0]           count_q, count_d;
   logic                 valid_q, full_q;
   logic [XLEN-1:0]      addr_q, addr_d;
   logic [ERR_CNT_W-1:0] errc_q, errc_d;
   logic                 push, pop;

   imm_pack u_imm_pack (
      .fmt     (in_fmt),
      .opcode  (in_opcode),
      .rd      (in_rd),
      .rs1     (in_rs1),
      .rs2     (in_rs2),
      .funct3  (in_funct3),
      .imm     (in_imm),
      .instr_c (pack_instr),
      .err_c   (pack_err)
   );

   assign new_entry.instr = pack_instr;
   assign new_entry.err   = pack_err;

   // Ready depends only on registered fullness plus the flush/reset inputs,
   // never on out_ready.
   assign in_ready = ~full_q & ~clear & ~rst;
   assign push     = in_valid & in_ready;
   assign pop      = valid_q & out_ready;

   // Next-state: head slot drives the outputs, tail slot holds the second entry.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      addr_d  = addr_q;
      errc_d  = errc_q;
      if (clear) begin
         count_d = 2'd0;
         addr_d  = BASE_ADDR;
      end else begin
         if (pop) addr_d = addr_q + 32'd4;
         if (push && pack_err && (errc_q != 8'hFF)) errc_d = errc_q + 8'd1;
         case ({push, pop})
            2'b10: begin
               if (count_q == 2'd0) head_d = new_entry;
               else                 tail_d = new_entry;
               count_d = count_q + 2'd1;
            end
            2'b01: begin
               if (count_q == 2'd2) head_d = tail_q;
               count_d = count_q - 2'd1;
            end
            2'b11: begin
               if (count_q == 2'd1) begin
                  head_d = new_entry;
               end else begin
                  head_d = tail_q;
                  tail_d = new_entry;
               end
            end
            default: ;
         endcase
      end
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
         valid_q <= 1'b0;
         full_q  <= 1'b0;
         addr_q  <= BASE_ADDR;
         errc_q  <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         valid_q <= (count_d != 2'd0);
         full_q  <= (count_d == 2'd2);
         addr_q  <= addr_d;
         errc_q  <= errc_d;
      end
   end

   assign out_valid = valid_q;
   assign out_instr = head_q.instr;
   assign out_err   = head_q.err;
   assign out_addr  = addr_q;
   assign err_count = errc_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed literal cases, then randomized traffic
// checked every cycle against a queue-based behavioural model.
module tb_instr_encoder;
   import riscv_pkg::*;

   localparam logic [31:0] BASE = 32'hFFFF_FFF0;
   localparam int PICKS[11] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096, 0, -1};

   logic        clk = 1'b0;
   logic        rst, clear, in_valid, in_ready, out_valid, out_ready, out_err;
   logic [1:0]  in_fmt;
   logic [6:0]  in_opcode;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [2:0]  in_funct3;
   logic [31:0] in_imm, out_instr, out_addr;
   logic [7:0]  err_count;

   always #5 clk = ~clk;

   instr_encoder #(.BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
      .err_count(err_count)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [31:0] instr;
      logic        err;
      logic [1:0]  fmt;
      logic [31:0] imm;
   } ent_t;

   ent_t        q[$];
   logic [31:0] m_addr;
   int          m_errc;
   bit          m_on = 1'b0;

   function automatic ent_t model_enc(input logic [1:0] fmt, input logic [6:0] op,
                                      input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [2:0] f3,
                                      input logic [31:0] imm);
      ent_t        e;
      int          v;
      logic [31:0] common;
      v      = $signed(imm);
      common = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
      case (fmt)
         2'b01: begin
            e.instr = common | (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | ((imm & 32'h1F) << 7);
            e.err   = (v < -2048) || (v > 2047);
         end
         2'b10: begin
            e.instr = common | (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                    | (32'(rs2) << 20) | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
            e.err   = (v < -4096) || (v > 4094) || (v % 2 != 0);
         end
         default: begin
            e.instr = common | ((imm & 32'hFFF) << 20) | (32'(rd) << 7);
            e.err   = (fmt == 2'b11) || (v < -2048) || (v > 2047);
         end
      endcase
      e.fmt = fmt;
      e.imm = imm;
      return e;
   endfunction

   // Model update on each rising edge from the same inputs the DUT sees.
   always @(posedge clk) begin
      int   n;
      ent_t e;
      if (rst) begin
         q.delete();
         m_addr = BASE;
         m_errc = 0;
         m_on   = 1'b1;
      end else if (m_on) begin
         if (clear) begin
            q.delete();
            m_addr = BASE;
         end else begin
            n = q.size();
            if (n > 0 && out_ready) begin
               void'(q.pop_front());
               m_addr = m_addr + 32'd4;
            end
            if (in_valid && n < 2) begin
               e = model_enc(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm);
               q.push_back(e);
               if (e.err && m_errc < 255) m_errc++;
            end
         end
      end
   end

   // Compare process: every falling edge once the model is live.
   always @(negedge clk) begin
      if (m_on) begin
         chk("in_ready", 32'(in_ready), 32'((q.size() < 2) && !clear && !rst));
         chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
         chk("out_addr", out_addr, m_addr);
         chk("err_count", 32'(err_count), 32'(m_errc));
         if (q.size() > 0) begin
            chk("out_instr", out_instr, q[0].instr);
            chk("out_err", 32'(out_err), 32'(q[0].err));
            if (!q[0].err)
               chk("round_trip", imm_extend(fmt_e'(q[0].fmt), out_instr), q[0].imm);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic at_neg();
      @(negedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input int imm);
      in_valid  = 1'b1;
      in_fmt    = fmt;
      in_opcode = op;
      in_rd     = rd;
      in_rs1    = rs1;
      in_rs2    = rs2;
      in_funct3 = f3;
      in_imm    = 32'(imm);
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   function automatic logic [31:0] rand_imm(input logic [1:0] fmt);
      int v;
      case ($urandom_range(0, 4))
         0: v = int'($urandom);
         1: v = PICKS[$urandom_range(0, 10)];
         default: begin
            if (fmt == 2'b10) v = (int'($urandom_range(0, 8190)) - 4096) & ~1;
            else              v = int'($urandom_range(0, 4095)) - 2048;
         end
      endcase
      return 32'(v);
   endfunction

   // ---------------- test sequence ----------------
   initial begin
      ent_t e;
      rst = 1'b1; clear = 1'b0; out_ready = 1'b0;
      in_valid = 1'b0; in_fmt = '0; in_opcode = '0; in_rd = '0;
      in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_imm = '0;

      // Pin the model against hand-encoded words.
      e = model_enc(2'b00, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
      chk("model_I", e.instr, 32'h0050_0093);
      e = model_enc(2'b01, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8);
      chk("model_S", e.instr, 32'h0020_A423);
      e = model_enc(2'b10, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, -32'sd8);
      chk("model_B", e.instr, 32'hFE20_8CE3);
      e = model_enc(2'b10, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3);
      chk("model_B_err", 32'(e.err), 32'd1);

      repeat (2) tick();
      rst = 1'b0;
      at_neg();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);
      chk("rst_out_err", 32'(out_err), 32'd0);
      chk("rst_out_addr", out_addr, BASE);
      chk("rst_err_count", 32'(err_count), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // I-type, one-cycle latency.
      send(2'b00, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 5);
      tick(); idle(); at_neg();
      chk("I_instr", out_instr, 32'h0050_0093);
      chk("I_addr", out_addr, BASE);
      chk("I_err", 32'(out_err), 32'd0);
      out_ready = 1'b1;
      tick();

      // S-type.
      send(2'b01, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 8);
      tick(); idle(); at_neg();
      chk("S_instr", out_instr, 32'h0020_A423);
      chk("S_addr", out_addr, BASE + 32'd4);
      tick();

      // B-type.
      send(2'b10, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, -8);
      tick(); idle(); at_neg();
      chk("B_instr", out_instr, 32'hFE20_8CE3);
      chk("B_addr", out_addr, BASE + 32'd8);
      tick();

      // Error cases; address wraps across 0xFFFFFFFC -> 0.
      send(2'b00, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 2048);
      tick(); idle(); at_neg();
      chk("errI_err", 32'(out_err), 32'd1);
      chk("errI_addr", out_addr, 32'hFFFF_FFFC);
      tick();
      send(2'b10, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 3);
      tick(); idle(); at_neg();
      chk("errB_err", 32'(out_err), 32'd1);
      chk("wrap_addr", out_addr, 32'h0000_0000);
      tick();
      send(2'b11, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 5);
      tick(); idle(); at_neg();
      chk("errF_err", 32'(out_err), 32'd1);
      tick(); at_neg();
      chk("err_count_3", 32'(err_count), 32'd3);

      // Backpressure: three requests, only two fit.
      out_ready = 1'b0;
      send(2'b00, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 1); tick();
      send(2'b00, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 2); tick();
      send(2'b00, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 3); tick();
      at_neg();
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_head", out_instr, 32'h0010_0113);
      tick(); at_neg();
      chk("bp_head_stable", out_instr, 32'h0010_0113);
      out_ready = 1'b1;
      #1;
      chk("bp_ready_no_comb", 32'(in_ready), 32'd0);
      tick(); idle(); at_neg();
      chk("bp_second", out_instr, 32'h0020_0193);
      tick(); at_neg();
      chk("bp_drained", 32'(out_valid), 32'd0);

      // Clear with two entries queued.
      out_ready = 1'b0;
      send(2'b00, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 4); tick();
      send(2'b00, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 4); tick();
      clear = 1'b1;
      send(2'b00, 7'h13, 5'd6, 5'd0, 5'd0, 3'd0, 9);
      #1;
      chk("clr_in_ready", 32'(in_ready), 32'd0);
      tick(); clear = 1'b0; idle(); at_neg();
      chk("clr_out_valid", 32'(out_valid), 32'd0);
      chk("clr_err_kept", 32'(err_count), 32'd3);
      send(2'b00, 7'h13, 5'd6, 5'd0, 5'd0, 3'd0, 7);
      tick(); idle(); at_neg();
      chk("clr_next_addr", out_addr, BASE);
      chk("clr_next_instr", out_instr, 32'h0070_0313);

      // Reset (together with clear) with two entries queued.
      send(2'b00, 7'h13, 5'd7, 5'd0, 5'd0, 3'd0, 1); tick(); idle();
      rst = 1'b1; clear = 1'b1;
      tick(); rst = 1'b0; clear = 1'b0; at_neg();
      chk("mrst_out_valid", 32'(out_valid), 32'd0);
      chk("mrst_err_count", 32'(err_count), 32'd0);
      chk("mrst_out_instr", out_instr, 32'd0);
      send(2'b00, 7'h13, 5'd6, 5'd0, 5'd0, 3'd0, 7);
      tick(); idle(); at_neg();
      chk("mrst_next_addr", out_addr, BASE);
      chk("mrst_next_instr", out_instr, 32'h0070_0313);
      out_ready = 1'b1;
      tick();

      // Randomized traffic with occasional flushes.
      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         in_fmt    = 2'($urandom_range(0, 3));
         in_opcode = 7'($urandom);
         in_rd     = 5'($urandom);
         in_rs1    = 5'($urandom);
         in_rs2    = 5'($urandom);
         in_funct3 = 3'($urandom);
         in_imm    = rand_imm(in_fmt);
         out_ready = ($urandom_range(0, 9) < 6);
         clear     = ($urandom_range(0, 99) == 0);
         tick();
      end
      idle(); clear = 1'b0; out_ready = 1'b1;
      repeat (4) tick();
      at_neg();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
